fifo_sync_flags: RTL and testbench

Single-clock, parametrised successor to the dual-clock fifo. Supports non-power-of-two depth and a selectable read mode: standard registered read or first-word-fall-through (FWFT). Provides an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Used as the general buffering element between single-clock pipeline stages.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 36 +++
 rtl/fifo_sync_flags.sv | 163 ++++++++++++++++
 tb/tb_fifo_sync_flags.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and width helpers for the synchronous fifo family
//
// Contents:
//   FIFO_MODE_STD  : registered read, data valid one cycle after an accepted read
//   FIFO_MODE_FWFT : first-word-fall-through, head entry always presented
//   ptr_w(depth)   : pointer width, at least one bit even for tiny depths
//   cnt_w(depth)   : occupancy counter width, able to hold 0..depth inclusive
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, sync write, async read
//
// Ports:
//   clk     : write clock
//   wr_en   : store wr_data at wr_addr on the rising edge
//   wr_addr : write address, always < DEPTH when wr_en is high
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational contents of entry rd_addr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately left without reset so it maps onto plain flops/RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock fifo with count, thresholds, sticky errors, std/FWFT read
//
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   data_wr, wr_en            : write side; write dropped while fifo_full
//   fifo_full, almost_full    : count == DEPTH, count >= AF_THRESH
//   rd_en                     : read request (std) / pop acknowledge (FWFT)
//   data_rd, data_rd_valid    : read data and its qualifier
//   fifo_empty, almost_empty  : count == 0, count <= AE_THRESH
//   count                     : current occupancy
//   overflow, underflow       : sticky error flags, cleared by clr_err
//   clr_err                   : clears both error flags (a same-cycle set wins)
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_wr,
  input  logic                     wr_en,
  output logic                     fifo_full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_rd,
  output logic                     data_rd_valid,
  output logic                     fifo_empty,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_sync_flags: FWFT must be 0 or 1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags; a write while full is dropped
  // even when a read frees a slot in the same cycle.
  assign wr_acc = wr_en && !fifo_full;
  assign rd_acc = rd_en && !fifo_empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are computed from next-count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      fifo_full    <= (count_nxt == CNT_FULL);
      fifo_empty   <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_LEVEL);
      almost_empty <= (count_nxt <= AE_LEVEL);
    end
  end

  // Sticky errors: set has priority over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && fifo_empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_wr),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry is presented directly; forced to zero while empty so the
    // unreset storage never leaks onto data_rd.
    assign data_rd       = fifo_empty ? '0 : mem_rd_data;
    assign data_rd_valid = !fifo_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          data_q <= mem_rd_data;
        end
      end
    end

    assign data_rd       = data_q;
    assign data_rd_valid = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - scoreboard bench for fifo_sync_flags, standard and FWFT instances
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       s_rst, s_wr_en, s_rd_en, s_clr;
  logic [7:0] s_data_wr, s_data_rd;
  logic       s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_udf;
  logic [3:0] s_count;

  // FWFT instance
  logic       f_rst, f_wr_en, f_rd_en, f_clr;
  logic [7:0] f_data_wr, f_data_rd;
  logic       f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_udf;
  logic [3:0] f_count;

  fifo_sync_flags u_std (
    .clk(clk), .rst(s_rst), .data_wr(s_data_wr), .wr_en(s_wr_en),
    .fifo_full(s_full), .almost_full(s_af), .rd_en(s_rd_en),
    .data_rd(s_data_rd), .data_rd_valid(s_valid), .fifo_empty(s_empty),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_udf), .clr_err(s_clr)
  );

  fifo_sync_flags #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .data_wr(f_data_wr), .wr_en(f_wr_en),
    .fifo_full(f_full), .almost_full(f_af), .rd_en(f_rd_en),
    .data_rd(f_data_rd), .data_rd_valid(f_valid), .fifo_empty(f_empty),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(f_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sq[$];
  logic [7:0] fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change and state is checked 2 time units after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitors sample on the falling edge, decoupled from stimulus.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_unexpected_valid: got data 0x%0h expected no read", s_data_rd);
      end else begin
        chk("std_read_data", s_data_rd, sq.pop_front());
      end
    end
    if (f_rd_en === 1'b1 && f_valid === 1'b1) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwft_unexpected_pop: got data 0x%0h expected no pop", f_data_rd);
      end else begin
        chk("fwft_pop_data", f_data_rd, fq.pop_front());
      end
    end
  end

  initial begin
    int exp_c;
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr = 1'b0; s_data_wr = 8'h00;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr = 1'b0; f_data_wr = 8'h00;
    cyc();
    s_rst = 1'b0; f_rst = 1'b0;

    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data_rd, 0);

    // Write 15 words into a 12-deep fifo
    for (int i = 1; i <= 15; i++) begin
      s_wr_en = 1'b1; s_data_wr = 8'(i);
      cyc();
      exp_c = (i < 12) ? i : 12;
      chk("wr_count", s_count, exp_c);
      chk("wr_full", s_full, i >= 12);
      chk("wr_af", s_af, exp_c >= 10);
      chk("wr_ovf", s_ovf, i >= 13);
    end
    s_wr_en = 1'b0;

    // Read 15 cycles; 12 words come back
    for (int i = 1; i <= 15; i++) begin
      s_rd_en = 1'b1;
      if (i <= 12) sq.push_back(8'(i));
      cyc();
      exp_c = (i < 12) ? 12 - i : 0;
      chk("rd_count", s_count, exp_c);
      chk("rd_empty", s_empty, i >= 12);
      chk("rd_ae", s_ae, exp_c <= 2);
      chk("rd_udf", s_udf, i >= 13);
    end
    s_rd_en = 1'b0;
    cyc();

    s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;
    chk("clr_ovf", s_ovf, 0);
    chk("clr_udf", s_udf, 0);

    // Pointer wrap: 20 x (write 7, read 7)
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 7; k++) begin
        s_wr_en = 1'b1; s_data_wr = 8'(it * 7 + k + 16);
        cyc();
      end
      s_wr_en = 1'b0;
      for (int k = 0; k < 7; k++) begin
        s_rd_en = 1'b1;
        sq.push_back(8'(it * 7 + k + 16));
        cyc();
      end
      s_rd_en = 1'b0;
    end
    cyc();
    chk("wrap_count", s_count, 0);
    chk("wrap_empty", s_empty, 1);
    chk("wrap_ovf", s_ovf, 0);
    chk("wrap_udf", s_udf, 0);

    // Simultaneous read+write while full: write dropped
    for (int k = 0; k < 12; k++) begin
      s_wr_en = 1'b1; s_data_wr = 8'(8'h40 + k);
      cyc();
    end
    chk("fill_full", s_full, 1);
    s_wr_en = 1'b1; s_data_wr = 8'hEE; s_rd_en = 1'b1;
    sq.push_back(8'h40);
    cyc();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    chk("full_rw_count", s_count, 11);
    chk("full_rw_ovf", s_ovf, 1);
    chk("full_rw_full", s_full, 0);
    for (int k = 1; k < 12; k++) begin
      s_rd_en = 1'b1;
      sq.push_back(8'(8'h40 + k));
      cyc();
    end
    s_rd_en = 1'b0;
    chk("drain_count", s_count, 0);
    s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;

    // Simultaneous read+write while empty: read rejected, no bypass
    s_wr_en = 1'b1; s_data_wr = 8'h77; s_rd_en = 1'b1;
    cyc();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    chk("empty_rw_count", s_count, 1);
    chk("empty_rw_udf", s_udf, 1);
    chk("empty_rw_ovf", s_ovf, 0);
    chk("empty_rw_empty", s_empty, 0);
    s_rd_en = 1'b1;
    sq.push_back(8'h77);
    cyc();
    s_rd_en = 1'b0;
    cyc();
    chk("empty_rw_final", s_count, 0);

    // Reset mid-burst at count 6 (underflow still set from above)
    for (int k = 0; k < 6; k++) begin
      s_wr_en = 1'b1; s_data_wr = 8'(8'h90 + k);
      cyc();
    end
    chk("burst_count", s_count, 6);
    s_rst = 1'b1; s_wr_en = 1'b1; s_rd_en = 1'b1;
    cyc();
    s_rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
    chk("mrst_count", s_count, 0);
    chk("mrst_empty", s_empty, 1);
    chk("mrst_ovf", s_ovf, 0);
    chk("mrst_udf", s_udf, 0);
    chk("mrst_valid", s_valid, 0);
    chk("mrst_data", s_data_rd, 0);

    // clr_err together with an overflow event: set wins
    for (int k = 0; k < 12; k++) begin
      s_wr_en = 1'b1; s_data_wr = 8'(8'hB0 + k);
      cyc();
    end
    s_wr_en = 1'b1; s_clr = 1'b1;
    cyc();
    s_wr_en = 1'b0; s_clr = 1'b0;
    chk("setwin_ovf", s_ovf, 1);
    chk("setwin_count", s_count, 12);
    s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;
    chk("clr_after_ovf", s_ovf, 0);

    // FWFT: head visible without rd_en
    f_wr_en = 1'b1; f_data_wr = 8'hA5;
    cyc();
    f_wr_en = 1'b0;
    chk("fwft_head", f_data_rd, 8'hA5);
    chk("fwft_valid", f_valid, 1);
    chk("fwft_count1", f_count, 1);
    f_rd_en = 1'b1;
    fq.push_back(8'hA5);
    cyc();
    f_rd_en = 1'b0;
    chk("fwft_pop_valid", f_valid, 0);
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_count", f_count, 0);
    chk("fwft_pop_udf", f_udf, 0);

    f_wr_en = 1'b1; f_data_wr = 8'h3C;
    cyc();
    f_data_wr = 8'hC3;
    cyc();
    f_wr_en = 1'b0;
    chk("fwft_head2", f_data_rd, 8'h3C);
    chk("fwft_count2", f_count, 2);
    f_rd_en = 1'b1;
    fq.push_back(8'h3C);
    cyc();
    fq.push_back(8'hC3);
    cyc();
    f_rd_en = 1'b0;
    chk("fwft_drain_empty", f_empty, 1);
    cyc();

    chk("std_sb_drained", sq.size(), 0);
    chk("fwft_sb_drained", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
